mask_row_packer: RTL
====================

Name: mask_row_packer

Overview:
- Receiving end of the serial mask stream produced by the pattern generator (`rp_mask_bit`/`rp_valid`).
- Packs mask bits, one per pixel, into `WORD_W`-bit words aligned to sensor rows.
- Tags each word with row index and end-of-row, and signals end of frame.
- Buffers words in a small FIFO so the downstream mask-memory writer can apply backpressure.

Parameters:
- image_sensor_w, 300, pixels per row (bits per row)
- image_sensor_h, 300, rows per frame
- WORD_W, 32, output word width in bits
- FIFO_DEPTH, 2, output word buffer depth (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- clk_en  in  1  clock enable; when 0, all state is frozen
- clear  in  1  synchronous frame restart; takes priority over stream input
- rp_mask_bit  in  1  serial mask bit; first bit received is pixel 0 of the row
- rp_valid  in  1  `rp_mask_bit` is valid this cycle
- rp_ready  out  1  packer can accept a bit (FIFO not full)
- mask_word  out  WORD_W  packed word; bit 0 is the earliest pixel
- mask_valid  out  1  FIFO head word valid
- mask_ready  in  1  downstream accepts head word
- mask_last  out  1  head word is the last word of its row
- mask_row  out  $clog2(image_sensor_h)  row index of head word
- frame_done  out  1  one-cycle pulse when the last word of row h-1 is popped
- overflow  out  1  sticky: a bit arrived while `rp_ready`=0

Behaviour:
- **Reset (async, `rst_n`=0):**
  - `mask_word`=0, `mask_valid`=0, `mask_last`=0, `mask_row`=0, `frame_done`=0, `overflow`=0, `rp_ready`=1.
  - Bit counter, pixel counter, row counter and FIFO pointers are cleared.
  - The partially assembled word is discarded.
- **`clk_en`=0:** no state changes. Outputs hold. No push or pop occurs even if `mask_ready`/`rp_valid` are high.
- **Accept:**
  - A bit is accepted on a rising edge with `clk_en`=1, `rp_valid`=1, `rp_ready`=1.
  - It is written to `shift[bit_cnt]`; `bit_cnt` and `pix_cnt` increment.
- **Word close:** the word closes on the accepted bit when `bit_cnt`==WORD_W-1 OR `pix_cnt`==image_sensor_w-1.
  - Unfilled upper bits of a partial final word are 0.
  - The closed word, `last` = (`pix_cnt`==w-1) and `row` are pushed into the FIFO on that same edge.
  - `bit_cnt` returns to 0 and the shift register is cleared.
  - At end of row, `pix_cnt` returns to 0 and the row counter increments, wrapping h-1→0.
- **Row geometry:** words per row = ceil(w/WORD_W). With defaults: 10 words, the last holding 12 valid bits.
- **Latency:** a word closed at edge N is visible at the FIFO head with `mask_valid`=1 after edge N. This holds when the FIFO was empty (1-cycle latency).
- **`rp_ready`:** `rp_ready` = (FIFO count < FIFO_DEPTH). It is combinational from registered count only and has no dependence on `mask_ready`.
- **Overflow:** if `rp_valid`=1 and `rp_ready`=0 (with `clk_en`=1):
  - The bit is dropped and counters do not advance.
  - `overflow` is set and stays 1 until reset or `clear`.
- **Pop:** occurs on an edge with `mask_valid`=1, `mask_ready`=1, `clk_en`=1.
- **Simultaneous push and pop when the FIFO is full:**
  - A push is only possible when `rp_ready`=1 before the edge, so push while full never occurs.
  - Push and pop on the same edge leaves the count unchanged.
- **frame_done:** asserted for exactly one enabled cycle after popping a word with `mask_last`=1 and `mask_row`==h-1.
- **`clear`** (with `clk_en`=1): has the same effect as reset except that `rst_n` is not involved.
  - FIFO is emptied, counters zeroed, `overflow` cleared.
  - `rp_valid` in the same cycle is ignored.
- **Reset or `clear` mid-row:** the partial row is lost. The next accepted bit is pixel 0 of row 0.

Test Plan (w=40, h=2, WORD_W=32, FIFO_DEPTH=2 unless stated):
1. Reset, then stream 40 bits of 0xA5A5A5A5 followed by 0xFF (8 bits) with `mask_ready`=1:
   - words 0xA5A5A5A5 (`last`=0, `row`=0) and 0x000000FF (`last`=1, `row`=0);
   - each appears 1 cycle after its closing bit.
2. Stream 80 all-ones bits with `mask_ready`=1:
   - 4 words: 0xFFFFFFFF, 0x000000FF, 0xFFFFFFFF, 0x000000FF, with `row` values 0,0,1,1;
   - `frame_done` pulses once after the 4th pop;
   - the next word shows `row`=0.
3. Hold `mask_ready`=0 and stream 40 bits:
   - after 2 words, `rp_ready`=0;
   - a 41st bit asserts `overflow`=1 and the word count stays 2;
   - raising `mask_ready` pops both words and `rp_ready` returns to 1.
4. Toggle `clk_en`=0 for 5 cycles mid-stream while `rp_valid`=1 and `mask_ready`=1: no bits are accepted, no pops occur, outputs are unchanged, and streaming resumes exactly.
5. Assert `clear` after 20 bits of a row with 1 word queued:
   - `mask_valid`=0, `overflow`=0;
   - the following 40 bits produce row-0 words only.
6. Default params (w=300): one row of alternating bits starting with 1 yields 9 × 0x55555555 plus 0x00000555 with `last`=1.

Source files
------------

// File: rtl/mask_row_packer.sv
// mask_row_packer: packs a serial per-pixel mask stream into row-aligned words
// and queues them with row index and end-of-row tags for a backpressured writer.
module mask_row_packer #(
   parameter int image_sensor_w = 300,
   parameter int image_sensor_h = 300,
   parameter int WORD_W = 32,
   parameter int FIFO_DEPTH = 2,
   localparam int RW = image_sensor_h > 1 ? $clog2(image_sensor_h) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clk_en,
   input  logic              clear,
   input  logic              rp_mask_bit,
   input  logic              rp_valid,
   output logic              rp_ready,
   output logic [WORD_W-1:0] mask_word,
   output logic              mask_valid,
   input  logic              mask_ready,
   output logic              mask_last,
   output logic [RW-1:0]     mask_row,
   output logic              frame_done,
   output logic              overflow
);
   localparam int BW = $clog2(WORD_W);
   localparam int XW = image_sensor_w > 1 ? $clog2(image_sensor_w) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [WORD_W-1:0] shift, fill;
   logic [WORD_W-1:0] mem_word [FIFO_DEPTH];
   logic              mem_last [FIFO_DEPTH];
   logic [RW-1:0]     mem_row  [FIFO_DEPTH];
   logic [BW-1:0]     bit_cnt;
   logic [XW-1:0]     pix_cnt;
   logic [RW-1:0]     row_cnt;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic              acc, eor, close, push, pop;

   assign rp_ready   = count < CW'(FIFO_DEPTH);
   assign mask_valid = count != '0;
   assign mask_word  = mask_valid ? mem_word[rd_ptr] : '0;
   assign mask_last  = mask_valid & mem_last[rd_ptr];
   assign mask_row   = mask_valid ? mem_row[rd_ptr] : '0;
   assign acc   = clk_en & ~clear & rp_valid & rp_ready;
   assign eor   = pix_cnt == XW'(image_sensor_w - 1);
   assign close = (bit_cnt == BW'(WORD_W - 1)) | eor;
   assign push  = acc & close;
   assign pop   = clk_en & ~clear & mask_valid & mask_ready;
   assign fill  = shift | (WORD_W'(rp_mask_bit) << bit_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift      <= '0;
         bit_cnt    <= '0;
         pix_cnt    <= '0;
         row_cnt    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else if (clk_en) begin
         if (clear) begin
            shift      <= '0;
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            row_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
         end else begin
            if (acc) begin
               shift   <= close ? '0 : fill;
               bit_cnt <= close ? '0 : bit_cnt + BW'(1);
               pix_cnt <= eor ? '0 : pix_cnt + XW'(1);
               if (eor)
                  row_cnt <= (row_cnt == RW'(image_sensor_h - 1)) ? '0 : row_cnt + RW'(1);
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count      <= count + CW'(push) - CW'(pop);
            frame_done <= pop & mem_last[rd_ptr] & (mem_row[rd_ptr] == RW'(image_sensor_h - 1));
            if (rp_valid & ~rp_ready) overflow <= 1'b1;
         end
      end
   end

   // Storage needs no reset: every head read is qualified by count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_word[wr_ptr] <= fill;
         mem_last[wr_ptr] <= eor;
         mem_row[wr_ptr]  <= row_cnt;
      end
   end
endmodule
